// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t        : FSM state encoding (3 bits)
//   HDR_BYTES      : bytes per little-endian word on the boot stream
//   NOP_INST       : instruction presented to the CPU while it is stalled
//   word_addr()    : byte address of word index idx above a base address
`timescale 1ns/1ps
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CSUM  = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam int          HDR_BYTES = 4;
    localparam logic [31:0] NOP_INST  = 32'h0000_0000;

    // Address arithmetic wraps modulo 2^32; bits [1:0] are forced to zero so
    // the DRAM always sees a word-aligned address.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] idx);
        logic [31:0] sum;
        sum = base + (idx << 2);
        return {sum[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous restart of the byte counter and shift register
//   in_valid    : a byte is consumed this cycle
//   in_data     : the byte
//   word        : word formed by the shift register plus the current byte
//                 (meaningful together with word_valid)
//   word_valid  : in_valid on the last byte of a word
//   held        : registered shift-register contents; after the last byte of
//                 a word it holds that complete word until the next byte
`timescale 1ns/1ps
module imem_boot_loader_byte_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [31:0] held
);

    logic [1:0]  byte_cnt;
    logic [31:0] shreg;

    // New bytes enter at the top and shift down, so the first byte of the
    // word ends up in bits [7:0].
    assign word       = {in_data, shreg[31:8]};
    assign word_valid = in_valid && (byte_cnt == 2'(HDR_BYTES - 1));
    assign held       = shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
            shreg    <= 32'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
            shreg    <= 32'd0;
        end else if (in_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= word;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader.
// Holds the CPU stalled, receives a framed program over a valid/ready byte
// stream (word count N, N payload words, XOR checksum byte; all little-endian),
// writes the words to imem, and after the checksum matches hands the imem
// read port to the CPU fetch path.
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_valid/s_data      : boot byte stream in
//   s_ready             : byte accepted when s_valid && s_ready at a rising edge
//   reload              : one-cycle pulse, honoured only in RUN, restarts loading
//   cpu_addr/cpu_inst   : CPU fetch address and returned instruction
//   cpu_stall           : 1 while the CPU must hold its PC
//   mem_addr/mem_wdata/mem_we/mem_rdata : imem DRAM port
//   load_done           : 1 in RUN
//   load_error          : 1 in ERR (terminal until rst_n)
//   fsm_state           : current FSM state, for observation
//
// Handshake: a byte transfers on a rising edge where s_valid && s_ready are
// both high; s_ready is a pure decode of the registered state, so it never
// depends on s_valid, and the source may hold s_valid low for any length.
`timescale 1ns/1ps
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    input  logic        reload,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_inst,
    output logic        cpu_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic        load_done,
    output logic        load_error,
    output state_t      fsm_state
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] n_words;
    logic [7:0]       csum;

    logic             accept;
    logic             pk_valid;
    logic             pk_clear;
    logic             pk_word_valid;
    logic [31:0]      pk_word;
    logic [31:0]      pk_held;
    logic             hdr_ok;
    logic             last_word;
    logic             reload_run;

    // Byte offset bits of the PC are irrelevant to a word-wide fetch.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign accept     = s_valid && s_ready;
    assign pk_valid   = accept && ((state == ST_HDR) || (state == ST_DATA));
    assign reload_run = (state == ST_RUN) && reload;
    assign pk_clear   = reload_run;
    assign hdr_ok     = (pk_word != 32'd0) && (pk_word <= 32'(MAX_WORDS));
    assign last_word  = ((word_cnt + CNT_W'(1)) == n_words);

    // The same packer assembles the header word and every payload word.
    imem_boot_loader_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pk_clear),
        .in_valid   (pk_valid),
        .in_data    (s_data),
        .word       (pk_word),
        .word_valid (pk_word_valid),
        .held       (pk_held)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HDR;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_nx   = state;
        s_ready    = 1'b0;
        mem_we     = 1'b0;
        cpu_stall  = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        cpu_inst   = NOP_INST;
        mem_addr   = word_addr(BASE_ADDR, 32'(word_cnt));
        unique case (state)
            ST_HDR: begin
                s_ready = 1'b1;
                if (pk_word_valid) begin
                    state_nx = hdr_ok ? ST_DATA : ST_ERR;
                end
            end
            ST_DATA: begin
                s_ready = 1'b1;
                if (pk_word_valid) begin
                    state_nx = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we   = 1'b1;
                state_nx = last_word ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                s_ready = 1'b1;
                if (accept) begin
                    state_nx = (s_data == csum) ? ST_RUN : ST_ERR;
                end
            end
            ST_RUN: begin
                cpu_stall = 1'b0;
                load_done = 1'b1;
                cpu_inst  = mem_rdata;
                mem_addr  = {cpu_addr[31:2], 2'b00};
                if (reload) begin
                    state_nx = ST_HDR;
                end
            end
            ST_ERR: begin
                load_error = 1'b1;
            end
            default: begin
                state_nx = ST_ERR;
            end
        endcase
    end

    assign mem_wdata = pk_held;
    assign fsm_state = state;

    // Word count, write index and running checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            n_words  <= '0;
            csum     <= 8'd0;
        end else if (reload_run) begin
            word_cnt <= '0;
            n_words  <= '0;
            csum     <= 8'd0;
        end else begin
            if ((state == ST_HDR) && pk_word_valid && hdr_ok) begin
                n_words <= pk_word[CNT_W-1:0];
            end
            if ((state == ST_DATA) && pk_valid) begin
                csum <= csum ^ s_data;
            end
            if (state == ST_WRITE) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

endmodule
